// File: rtl/branch_result_buffer.sv
// rtl/branch_result_buffer.sv - in-order result queue between branch unit and CDB arbiter
// Optional same-cycle bypass when empty: define BRANCH_RESULT_BUFFER_BYPASS_EN.
module branch_result_buffer #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 5,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     write_to_buffer,
  input  logic [XLEN-1:0]          next_instruction,
  input  logic                     redirect_mispredicted,
  input  logic [ROB_TAG_WIDTH-1:0] rob_tag_in,
  input  logic                     flush,
  input  logic                     cdb_grant,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_next_instruction,
  output logic                     out_redirect_mispredicted,
  output logic [ROB_TAG_WIDTH-1:0] out_rob_tag,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic                     mis;
    logic [ROB_TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  entry_t             in_e;
  entry_t             out_e;
  logic               empty;
  logic               bypass;
  logic               push;
  logic               pop;

  assign in_e  = {next_instruction, redirect_mispredicted, rob_tag_in};
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

`ifdef BRANCH_RESULT_BUFFER_BYPASS_EN
  assign bypass = empty && write_to_buffer && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed result that is granted in the same cycle is consumed and never stored.
  assign push = write_to_buffer && !full && !flush && !(bypass && cdb_grant);
  assign pop  = cdb_grant && !empty && !flush;

  assign out_e                     = bypass ? in_e : mem[head];
  assign out_valid                 = !empty || bypass;
  assign out_next_instruction      = out_e.pc;
  assign out_redirect_mispredicted = out_e.mis;
  assign out_rob_tag               = out_e.tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is deliberately unreset; out_valid qualifies the data outputs.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_e;
  end

endmodule

// File: tb/tb_branch_result_buffer.sv
// tb/tb_branch_result_buffer.sv - table-driven self-checking bench for branch_result_buffer
module tb_branch_result_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        write_to_buffer;
  logic [31:0] next_instruction;
  logic        redirect_mispredicted;
  logic [4:0]  rob_tag_in;
  logic        flush;
  logic        cdb_grant;
  logic        out_valid;
  logic [31:0] out_next_instruction;
  logic        out_redirect_mispredicted;
  logic [4:0]  out_rob_tag;
  logic        full;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  branch_result_buffer #(.XLEN(32), .ROB_TAG_WIDTH(5), .DEPTH(4)) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .write_to_buffer           (write_to_buffer),
    .next_instruction          (next_instruction),
    .redirect_mispredicted     (redirect_mispredicted),
    .rob_tag_in                (rob_tag_in),
    .flush                     (flush),
    .cdb_grant                 (cdb_grant),
    .out_valid                 (out_valid),
    .out_next_instruction      (out_next_instruction),
    .out_redirect_mispredicted (out_redirect_mispredicted),
    .out_rob_tag               (out_rob_tag),
    .full                      (full),
    .count                     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [4:0] tag;
    logic       fl;
    logic       gr;
    logic       ev;
    logic [4:0] etag;
    int         ecnt;
    logic       efull;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] dat(input logic [4:0] t);
    return 32'hB000_0000 | (32'(t) << 4);
  endfunction

  function automatic vec_t mk(input logic wr, input int tag, input logic fl, input logic gr,
                              input logic ev, input int etag, input int ecnt, input logic efull);
    vec_t v;
    v.wr = wr; v.tag = 5'(tag); v.fl = fl; v.gr = gr;
    v.ev = ev; v.etag = 5'(etag); v.ecnt = ecnt; v.efull = efull;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    write_to_buffer       = 1'b0;
    next_instruction      = '0;
    redirect_mispredicted = 1'b0;
    rob_tag_in            = '0;
    flush                 = 1'b0;
    cdb_grant             = 1'b0;
  endtask

  // Apply one cycle of stimulus, then sample the registered state after the edge.
  task automatic step(input logic wr, input logic [31:0] d, input logic m, input logic [4:0] t,
                      input logic fl, input logic gr);
    write_to_buffer       = wr;
    next_instruction      = d;
    redirect_mispredicted = m;
    rob_tag_in            = t;
    flush                 = fl;
    cdb_grant             = gr;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    #12;
    check("reset_valid", 32'(out_valid), 0);
    check("reset_count", 32'(count), 0);
    check("reset_full", 32'(full), 0);
    reset_n = 1'b1;

    // Single write with explicit payload, then grant.
    step(1'b1, 32'h0000_1000, 1'b1, 5'd3, 1'b0, 1'b0);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_pc", out_next_instruction, 32'h0000_1000);
    check("t1_mis", 32'(out_redirect_mispredicted), 1);
    check("t1_tag", 32'(out_rob_tag), 3);
    check("t1_count", 32'(count), 1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    check("t1_pop_valid", 32'(out_valid), 0);
    check("t1_pop_count", 32'(count), 0);

    // Fill to full, drop a 5th write, drain in order.
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 2, 0));
    vecs.push_back(mk(1, 2, 0, 0, 1, 0, 3, 0));
    vecs.push_back(mk(1, 3, 0, 0, 1, 0, 4, 1));
    vecs.push_back(mk(1, 7, 0, 0, 1, 0, 4, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 2, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    // Three entries, then six simultaneous write+grant cycles across the wrap.
    vecs.push_back(mk(1, 10, 0, 0, 1, 10, 1, 0));
    vecs.push_back(mk(1, 11, 0, 0, 1, 10, 2, 0));
    vecs.push_back(mk(1, 12, 0, 0, 1, 10, 3, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 13 + i, 0, 1, 1, 11 + i, 3, 0));
    // Flush with write and grant, ignored grant while empty, first write after flush.
    vecs.push_back(mk(1, 9, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 20, 0, 0, 1, 20, 1, 0));
    vecs.push_back(mk(1, 21, 0, 0, 1, 20, 2, 0));
    vecs.push_back(mk(1, 22, 0, 0, 1, 20, 3, 0));
    vecs.push_back(mk(1, 23, 0, 0, 1, 20, 4, 1));
    // Write while full is dropped even with a grant; the grant still pops.
    vecs.push_back(mk(1, 7, 0, 1, 1, 21, 3, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 22, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 23, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, dat(vecs[i].tag), vecs[i].tag[0], vecs[i].tag, vecs[i].fl, vecs[i].gr);
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].efull));
      if (vecs[i].ev) begin
        check($sformatf("v%0d_tag", i), 32'(out_rob_tag), 32'(vecs[i].etag));
        check($sformatf("v%0d_pc", i), out_next_instruction, dat(vecs[i].etag));
        check($sformatf("v%0d_mis", i), 32'(out_redirect_mispredicted), 32'(vecs[i].etag[0]));
      end
    end

    // Asynchronous reset mid-cycle with two entries held.
    step(1'b1, dat(5'd1), 1'b1, 5'd1, 1'b0, 1'b0);
    step(1'b1, dat(5'd2), 1'b0, 5'd2, 1'b0, 1'b0);
    check("rst_pre_count", 32'(count), 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 0);
    check("rst_async_full", 32'(full), 0);
    check("rst_async_count", 32'(count), 0);
    reset_n = 1'b1;
    step(1'b1, dat(5'd5), 1'b1, 5'd5, 1'b0, 1'b0);
    check("rst_w5_count", 32'(count), 1);
    check("rst_w5_tag", 32'(out_rob_tag), 5);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    check("rst_w5_alone", 32'(out_valid), 0);

`ifdef BRANCH_RESULT_BUFFER_BYPASS_EN
    // Same-cycle bypass on an empty buffer, consumed by a simultaneous grant.
    write_to_buffer       = 1'b1;
    next_instruction      = dat(5'd2);
    redirect_mispredicted = 1'b0;
    rob_tag_in            = 5'd2;
    cdb_grant             = 1'b1;
    #1;
    check("byp_valid", 32'(out_valid), 1);
    check("byp_tag", 32'(out_rob_tag), 2);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check("byp_count", 32'(count), 0);
    check("byp_after_valid", 32'(out_valid), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
